// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-producer FIFOs for ALU and LSU results,
// round-robin grant of one broadcast per cycle, flushed by reset or ROB rollback.
module cdb_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ROB_WIDTH   = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rollback_flag_from_rob,
  input  logic                  alu_valid,
  input  logic [ROB_WIDTH-1:0]  alu_rob_id,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [ROB_WIDTH-1:0]  lsu_rob_id,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  cdb_valid,
  output logic [ROB_WIDTH-1:0]  cdb_rob_id,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  cdb_src
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ROB_WIDTH + DATA_WIDTH;
  localparam int NSRC    = 2;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  logic                          flush;
  logic [NSRC-1:0]               src_valid;
  logic [NSRC-1:0]               src_ready;
  logic [NSRC-1:0]               src_nonempty;
  logic [NSRC-1:0]               push;
  logic [NSRC-1:0]               pop;
  logic [NSRC-1:0][ENTRY_W-1:0]  src_entry;
  logic [NSRC-1:0][ENTRY_W-1:0]  head_entry;

  logic                  rr_last_reg;
  logic                  grant_valid;
  logic                  grant_src;
  logic                  cdb_valid_reg;
  logic [ROB_WIDTH-1:0]  cdb_rob_id_reg;
  logic [DATA_WIDTH-1:0] cdb_data_reg;
  logic                  cdb_src_reg;

  assign flush        = rst_in | rollback_flag_from_rob;
  assign src_valid    = {lsu_valid, alu_valid};
  assign src_entry[0] = {alu_rob_id, alu_result};
  assign src_entry[1] = {lsu_rob_id, lsu_data};
  assign alu_ready    = src_ready[0];
  assign lsu_ready    = src_ready[1];

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_fifo
      logic [ENTRY_W-1:0] mem [QUEUE_DEPTH];
      logic [PTR_W-1:0]   head_reg;
      logic [PTR_W-1:0]   tail_reg;
      logic [CNT_W-1:0]   count_reg;
      logic [CNT_W-1:0]   count_next;

      // Ready looks only at the registered count: a full FIFO never accepts,
      // even in a cycle where it is also being popped.
      assign src_ready[gi]    = rdy_in && !flush && (count_reg < CNT_W'(QUEUE_DEPTH));
      assign src_nonempty[gi] = (count_reg != '0);
      assign push[gi]         = src_valid[gi] && src_ready[gi];
      assign head_entry[gi]   = mem[head_reg];

      always_comb begin
        count_next = count_reg;
        case ({push[gi], pop[gi]})
          2'b10:   count_next = count_reg + CNT_W'(1);
          2'b01:   count_next = count_reg - CNT_W'(1);
          default: count_next = count_reg;
        endcase
      end

      always_ff @(posedge clk_in) begin
        if (flush) begin
          head_reg  <= '0;
          tail_reg  <= '0;
          count_reg <= '0;
        end else begin
          if (push[gi]) tail_reg <= tail_reg + PTR_W'(1);
          if (pop[gi])  head_reg <= head_reg + PTR_W'(1);
          count_reg <= count_next;
        end
      end

      always_ff @(posedge clk_in) begin
        if (push[gi]) mem[tail_reg] <= src_entry[gi];
      end
    end
  endgenerate

  // Grant uses pre-push occupancy, so an entry written this edge waits a cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    if (rdy_in && !flush) begin
      if (src_nonempty[0] && src_nonempty[1]) begin
        grant_valid = 1'b1;
        grant_src   = ~rr_last_reg;
      end else if (src_nonempty[0]) begin
        grant_valid = 1'b1;
        grant_src   = SRC_ALU;
      end else if (src_nonempty[1]) begin
        grant_valid = 1'b1;
        grant_src   = SRC_LSU;
      end
    end
  end

  assign pop = grant_valid ? (grant_src ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_in) begin
    if (flush) begin
      rr_last_reg    <= SRC_LSU;
      cdb_valid_reg  <= 1'b0;
      cdb_rob_id_reg <= '0;
      cdb_data_reg   <= '0;
      cdb_src_reg    <= SRC_ALU;
    end else if (rdy_in) begin
      cdb_valid_reg <= grant_valid;
      if (grant_valid) begin
        {cdb_rob_id_reg, cdb_data_reg} <= head_entry[grant_src];
        cdb_src_reg <= grant_src;
        rr_last_reg <= grant_src;
      end
    end
  end

  assign cdb_valid  = cdb_valid_reg;
  assign cdb_rob_id = cdb_rob_id_reg;
  assign cdb_data   = cdb_data_reg;
  assign cdb_src    = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, then random traffic
// checked against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int QD = 2;
  localparam int NV = 32;
  localparam int NRAND = 800;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, rollback_flag_from_rob;
  logic          alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [RW-1:0] alu_rob_id, lsu_rob_id, cdb_rob_id;
  logic [DW-1:0] alu_result, lsu_data, cdb_data;
  logic          cdb_valid, cdb_src;

  cdb_arbiter #(.DATA_WIDTH(DW), .ROB_WIDTH(RW), .QUEUE_DEPTH(QD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rollback_flag_from_rob(rollback_flag_from_rob),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_result(alu_result), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rob_id(lsu_rob_id), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic rst; logic rdy; logic rb;
    logic av; logic [RW-1:0] at; logic [DW-1:0] ad;
    logic lv; logic [RW-1:0] lt; logic [DW-1:0] ld;
    logic e_ar; logic e_lr;
    logic e_v; logic [RW-1:0] e_t; logic [DW-1:0] e_d; logic e_s;
  } vec_t;

  typedef struct { logic [RW-1:0] tag; logic [DW-1:0] data; } ent_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  ent_t          mqa[$];
  ent_t          mql[$];
  ent_t          e;
  logic          m_rr, m_v, m_s, m_ar, m_lr;
  logic [RW-1:0] m_t;
  logic [DW-1:0] m_d;
  logic          r_rst, r_rdy, r_rb;
  logic          a_v, l_v;
  logic [RW-1:0] a_t, l_t;
  logic [DW-1:0] a_d, l_d;
  int            g;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rb,
                              input logic av, input logic [RW-1:0] at, input logic [DW-1:0] ad,
                              input logic lv, input logic [RW-1:0] lt, input logic [DW-1:0] ld,
                              input logic ar, input logic lr,
                              input logic v, input logic [RW-1:0] t, input logic [DW-1:0] d,
                              input logic s);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.rb = rb;
    r.av = av; r.at = at; r.ad = ad;
    r.lv = lv; r.lt = lt; r.ld = ld;
    r.e_ar = ar; r.e_lr = lr;
    r.e_v = v; r.e_t = t; r.e_d = d; r.e_s = s;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic rb,
                       input logic av, input logic [RW-1:0] at, input logic [DW-1:0] ad,
                       input logic lv, input logic [RW-1:0] lt, input logic [DW-1:0] ld);
    rst_in = rst; rdy_in = rdy; rollback_flag_from_rob = rb;
    alu_valid = av; alu_rob_id = at; alu_result = ad;
    lsu_valid = lv; lsu_rob_id = lt; lsu_data = ld;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, lone ALU result, then simultaneous push with ALU winning the tie
    vecs[0]  = mk(1,1,0, 0,0,0,        0,0,0,        0,0, 0,0,0,0);
    vecs[1]  = mk(0,1,0, 1,3,'h11,     0,0,0,        1,1, 0,0,0,0);
    vecs[2]  = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 1,3,'h11,0);
    vecs[3]  = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 0,3,'h11,0);
    vecs[4]  = mk(1,1,0, 0,0,0,        0,0,0,        0,0, 0,0,0,0);
    vecs[5]  = mk(0,1,0, 1,1,'hA1,     1,2,'hB2,     1,1, 0,0,0,0);
    vecs[6]  = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 1,1,'hA1,0);
    vecs[7]  = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 1,2,'hB2,1);
    vecs[8]  = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 0,2,'hB2,1);
    // both streaming: FIFOs fill, ready drops in full cycles even while popping
    vecs[9]  = mk(0,1,0, 1,4,'h04,     1,5,'h05,     1,1, 0,2,'hB2,1);
    vecs[10] = mk(0,1,0, 1,6,'h06,     1,7,'h07,     1,1, 1,4,'h04,0);
    vecs[11] = mk(0,1,0, 1,8,'h08,     1,9,'h09,     1,0, 1,5,'h05,1);
    vecs[12] = mk(0,1,0, 1,'hA,'h0A,   1,9,'h09,     0,1, 1,6,'h06,0);
    vecs[13] = mk(0,1,0, 1,'hA,'h0A,   1,'hB,'h0B,   1,0, 1,7,'h07,1);
    vecs[14] = mk(0,1,0, 0,0,0,        1,'hB,'h0B,   0,1, 1,8,'h08,0);
    vecs[15] = mk(0,1,0, 0,0,0,        0,0,0,        1,0, 1,9,'h09,1);
    vecs[16] = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 1,'hA,'h0A,0);
    vecs[17] = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 1,'hB,'h0B,1);
    vecs[18] = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 0,'hB,'h0B,1);
    // rollback with both FIFOs occupied and an LSU offer pending
    vecs[19] = mk(0,1,0, 1,'hC,'hC0,   1,'hD,'hD0,   1,1, 0,'hB,'h0B,1);
    vecs[20] = mk(0,1,1, 0,0,0,        1,'hE,'hE0,   0,0, 0,0,0,0);
    vecs[21] = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 0,0,0,0);
    vecs[22] = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 0,0,0,0);
    // rdy_in low for three cycles with an ALU entry pending
    vecs[23] = mk(0,1,0, 1,1,'h21,     0,0,0,        1,1, 0,0,0,0);
    vecs[24] = mk(0,1,0, 1,3,'h23,     0,0,0,        1,1, 1,1,'h21,0);
    vecs[25] = mk(0,0,0, 0,0,0,        1,2,'h22,     0,0, 1,1,'h21,0);
    vecs[26] = mk(0,0,0, 0,0,0,        1,2,'h22,     0,0, 1,1,'h21,0);
    vecs[27] = mk(0,0,0, 0,0,0,        1,2,'h22,     0,0, 1,1,'h21,0);
    vecs[28] = mk(0,1,0, 0,0,0,        1,2,'h22,     1,1, 1,3,'h23,0);
    vecs[29] = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 1,2,'h22,1);
    vecs[30] = mk(0,1,0, 0,0,0,        0,0,0,        1,1, 0,2,'h22,1);
    // reset wins even while rdy_in is low
    vecs[31] = mk(1,0,0, 0,0,0,        0,0,0,        0,0, 0,0,0,0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rb, vecs[i].av, vecs[i].at, vecs[i].ad,
            vecs[i].lv, vecs[i].lt, vecs[i].ld);
      #1;
      chk($sformatf("vec%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
      chk($sformatf("vec%0d lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_lr));
      @(posedge clk_in);
      #1;
      chk($sformatf("vec%0d cdb_valid", i), 32'(cdb_valid), 32'(vecs[i].e_v));
      chk($sformatf("vec%0d cdb_rob_id", i), 32'(cdb_rob_id), 32'(vecs[i].e_t));
      chk($sformatf("vec%0d cdb_data", i), cdb_data, vecs[i].e_d);
      chk($sformatf("vec%0d cdb_src", i), 32'(cdb_src), 32'(vecs[i].e_s));
      $display("vec %0d: rdy=%0b cdb v=%0b tag=%0h data=%0h src=%0b",
               i, vecs[i].rdy, cdb_valid, cdb_rob_id, cdb_data, cdb_src);
    end

    // random traffic against the queue model
    m_rr = 1'b1; m_v = 1'b0; m_t = '0; m_d = '0; m_s = 1'b0;
    a_v = 1'b0; l_v = 1'b0; a_t = '0; l_t = '0; a_d = '0; l_d = '0;
    for (int c = 0; c < NRAND; c++) begin
      r_rst = (c == 0) || ($urandom_range(0, 199) == 0);
      r_rb  = ($urandom_range(0, 99) < 3);
      r_rdy = ($urandom_range(0, 99) < 85);
      if (!a_v && $urandom_range(0, 99) < 70) begin
        a_v = 1'b1; a_t = RW'($urandom); a_d = $urandom;
      end
      if (!l_v && $urandom_range(0, 99) < 70) begin
        l_v = 1'b1; l_t = RW'($urandom); l_d = $urandom;
      end
      drive(r_rst, r_rdy, r_rb, a_v, a_t, a_d, l_v, l_t, l_d);
      #1;
      m_ar = r_rdy && !r_rst && !r_rb && (mqa.size() < QD);
      m_lr = r_rdy && !r_rst && !r_rb && (mql.size() < QD);
      chk("rnd alu_ready", 32'(alu_ready), 32'(m_ar));
      chk("rnd lsu_ready", 32'(lsu_ready), 32'(m_lr));
      @(posedge clk_in);
      if (r_rst || r_rb) begin
        mqa.delete(); mql.delete();
        m_rr = 1'b1; m_v = 1'b0; m_t = '0; m_d = '0; m_s = 1'b0;
        a_v = 1'b0; l_v = 1'b0;
      end else if (r_rdy) begin
        g = -1;
        if (mqa.size() > 0 && mql.size() > 0) g = (m_rr == 1'b1) ? 0 : 1;
        else if (mqa.size() > 0) g = 0;
        else if (mql.size() > 0) g = 1;
        if (g == 0) begin
          e = mqa.pop_front();
          m_v = 1'b1; m_t = e.tag; m_d = e.data; m_s = 1'b0; m_rr = 1'b0;
        end else if (g == 1) begin
          e = mql.pop_front();
          m_v = 1'b1; m_t = e.tag; m_d = e.data; m_s = 1'b1; m_rr = 1'b1;
        end else begin
          m_v = 1'b0;
        end
        if (a_v && m_ar) begin
          e.tag = a_t; e.data = a_d; mqa.push_back(e); a_v = 1'b0;
        end
        if (l_v && m_lr) begin
          e.tag = l_t; e.data = l_d; mql.push_back(e); l_v = 1'b0;
        end
      end
      #1;
      chk("rnd cdb_valid", 32'(cdb_valid), 32'(m_v));
      chk("rnd cdb_rob_id", 32'(cdb_rob_id), 32'(m_t));
      chk("rnd cdb_data", cdb_data, m_d);
      chk("rnd cdb_src", 32'(cdb_src), 32'(m_s));
      if (m_v)
        $display("cyc %0d: broadcast src=%0b tag=%0h data=%08h", c, m_s, m_t, m_d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
